// File: rtl/piso_tx.sv
// Parallel-in, serial-out transmitter: takes a word over valid/ready and shifts it
// out MSB first, holding each bit for DIV cycles with a sample strobe on its last cycle.
module piso_tx #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic [WIDTH-1:0] i_DATA,
    input  logic             i_VALID,
    output logic             o_READY,
    output logic             o_SDO,
    output logic             o_SFT,
    output logic             o_BUSY,
    output logic             o_DONE
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [BW-1:0]    bit_cnt;
    logic [DW-1:0]    div_cnt;

    // NOTE: every output is computed one cycle ahead and registered, so o_SFT is
    // raised on the edge that moves the divider onto its last count, not on the edge after.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state   <= IDLE;
            sreg    <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            o_READY <= 1'b0;
            o_SDO   <= 1'b0;
            o_SFT   <= 1'b0;
            o_BUSY  <= 1'b0;
            o_DONE  <= 1'b0;
        end else begin
            o_SFT  <= 1'b0;
            o_DONE <= 1'b0;
            case (state)
                IDLE: begin
                    o_READY <= 1'b1;
                    o_BUSY  <= 1'b0;
                    o_SDO   <= 1'b0;
                    if (i_VALID && o_READY) begin
                        sreg    <= i_DATA;
                        bit_cnt <= '0;
                        div_cnt <= '0;
                        state   <= SHIFT;
                        o_READY <= 1'b0;
                        o_BUSY  <= 1'b1;
                        o_SDO   <= i_DATA[WIDTH-1];
                        o_SFT   <= (DIV_LAST == '0);
                    end
                end
                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        sreg    <= {sreg[WIDTH-2:0], 1'b0};
                        bit_cnt <= bit_cnt + 1'b1;
                        div_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            state  <= DONE;
                            o_DONE <= 1'b1;
                            o_BUSY <= 1'b0;
                            o_SDO  <= 1'b0;
                        end else begin
                            // Next bit is the one just below the current MSB.
                            o_SDO <= sreg[WIDTH-2];
                            o_SFT <= (DIV_LAST == '0);
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                        o_SFT   <= ((div_cnt + 1'b1) == DIV_LAST);
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    o_READY <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: three instances (8/4, 8/1, 16/2) share clock and reset,
// each scenario task compares outputs against hand-derived per-cycle expectations.
module tb_piso_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  data_a = '0, data_b = '0;
    logic [15:0] data_c = '0;
    logic        valid_a = 1'b0, valid_b = 1'b0, valid_c = 1'b0;
    logic [2:0]  ready, sdo, sft, busy, done;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(8), .DIV(4)) u_a (
        .i_CLK(clk), .i_RST(rst), .i_DATA(data_a), .i_VALID(valid_a),
        .o_READY(ready[0]), .o_SDO(sdo[0]), .o_SFT(sft[0]), .o_BUSY(busy[0]), .o_DONE(done[0])
    );
    piso_tx #(.WIDTH(8), .DIV(1)) u_b (
        .i_CLK(clk), .i_RST(rst), .i_DATA(data_b), .i_VALID(valid_b),
        .o_READY(ready[1]), .o_SDO(sdo[1]), .o_SFT(sft[1]), .o_BUSY(busy[1]), .o_DONE(done[1])
    );
    piso_tx #(.WIDTH(16), .DIV(2)) u_c (
        .i_CLK(clk), .i_RST(rst), .i_DATA(data_c), .i_VALID(valid_c),
        .o_READY(ready[2]), .o_SDO(sdo[2]), .o_SFT(sft[2]), .o_BUSY(busy[2]), .o_DONE(done[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word, wait (bounded) for ready, then pass the capture edge.
    task automatic start(input int sel, input logic [15:0] word);
        int n = 0;
        case (sel)
            0: begin data_a = word[7:0]; valid_a = 1'b1; end
            1: begin data_b = word[7:0]; valid_b = 1'b1; end
            default: begin data_c = word; valid_c = 1'b1; end
        endcase
        while (ready[sel] !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        total++;
        if (ready[sel] !== 1'b1) begin
            bad++;
            $display("FAIL start_ready inst %0d: ready=%b required 1", sel, ready[sel]);
        end
        tick();
    endtask

    // Called just after the capture edge; ends just after the edge where ready is back.
    task automatic check_word(input int sel, input int w, input int d,
                              input logic [15:0] word, input string name);
        logic [4:0] exp, got;
        for (int j = 0; j < w * d + 2; j++) begin
            if (j < w * d)
                exp = {word[w - 1 - j / d], (j % d == d - 1), 1'b1, 1'b0, 1'b0};
            else if (j == w * d)
                exp = 5'b00001;
            else
                exp = 5'b00010;
            got = {sdo[sel], sft[sel], busy[sel], ready[sel], done[sel]};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL %s cycle %0d: sdo/sft/busy/ready/done=%b required %b",
                         name, j, got, exp);
            end
            if (j < w * d + 1) tick();
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        total++;
        if ({ready, sdo, sft, busy, done} !== 15'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b required all 0", {ready, sdo, sft, busy, done});
        end
        tick();
        tick();
        total++;
        if ({ready, sdo, sft, busy, done} !== 15'b0) begin
            bad++;
            $display("FAIL reset_held: got %b required all 0", {ready, sdo, sft, busy, done});
        end
        rst = 1'b0;
        tick();
        total++;
        if (ready !== 3'b111 || sdo !== 3'b000 || busy !== 3'b000) begin
            bad++;
            $display("FAIL reset_release: ready=%b sdo=%b busy=%b required 111/000/000",
                     ready, sdo, busy);
        end
    endtask

    task automatic test_mid_reset();
        start(0, 16'h0081);
        valid_a = 1'b0;
        tick();
        total++;
        if (sdo[0] !== 1'b1 || busy[0] !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_pre: sdo=%b busy=%b required 1/1", sdo[0], busy[0]);
        end
        #3 rst = 1'b1;
        #1;
        total++;
        if ({ready, sdo, sft, busy, done} !== 15'b0) begin
            bad++;
            $display("FAIL mid_reset_async: got %b required all 0", {ready, sdo, sft, busy, done});
        end
        tick();
        rst = 1'b0;
        tick();
        total++;
        if (ready[0] !== 1'b1 || sdo[0] !== 1'b0 || done[0] !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_release: ready=%b sdo=%b done=%b required 1/0/0",
                     ready[0], sdo[0], done[0]);
        end
    endtask

    task automatic test_basic();
        start(0, 16'h00A5);
        valid_a = 1'b0;
        check_word(0, 8, 4, 16'h00A5, "a5_div4");
    endtask

    task automatic test_back_to_back();
        start(1, 16'h00FF);
        data_b = 8'h00;
        check_word(1, 8, 1, 16'h00FF, "ff_div1");
        tick();
        valid_b = 1'b0;
        check_word(1, 8, 1, 16'h0000, "00_div1");
    endtask

    task automatic test_data_hold();
        start(0, 16'h003C);
        data_a = 8'hC3;
        check_word(0, 8, 4, 16'h003C, "3c_hold");
        tick();
        valid_a = 1'b0;
        check_word(0, 8, 4, 16'h00C3, "c3_next");
    endtask

    task automatic test_abort();
        int dones = 0;
        start(0, 16'h0081);
        valid_a = 1'b0;
        repeat (12) tick();
        total++;
        if (busy[0] !== 1'b1) begin
            bad++;
            $display("FAIL abort_pre: busy=%b required 1", busy[0]);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (busy[0] !== 1'b0 || sdo[0] !== 1'b0 || done[0] !== 1'b0) begin
            bad++;
            $display("FAIL abort_async: busy=%b sdo=%b done=%b required 0/0/0",
                     busy[0], sdo[0], done[0]);
        end
        #1 rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done[0] === 1'b1) dones++;
        end
        total++;
        if (dones !== 0) begin
            bad++;
            $display("FAIL abort_no_done: done pulses=%0d required 0", dones);
        end
        start(0, 16'h0055);
        valid_a = 1'b0;
        check_word(0, 8, 4, 16'h0055, "55_after_abort");
    endtask

    task automatic test_wide();
        start(2, 16'h8001);
        valid_c = 1'b0;
        check_word(2, 16, 2, 16'h8001, "8001_w16_div2");
    endtask

    initial begin
        test_reset();
        test_mid_reset();
        test_basic();
        test_back_to_back();
        test_data_hold();
        test_abort();
        test_wide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
